// File: rtl/key_filter_debounce.sv
// key_filter_debounce
// Debouncer for an active-low push button. The raw key is synchronised to clk
// and each press or release must hold a stable level for CNT_MAX cycles
// before it is accepted.
//
// Ports:
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   key          raw button, asynchronous to clk (0 = pressed)
//   start        one-cycle pulse per debounced press (launch trigger)
//   key_release  one-cycle pulse per debounced release
//   key_state    debounced level (1 = pressed)
module key_filter_debounce #(
  parameter int unsigned CNT_MAX = 1_000_000,
  parameter int unsigned CNT_W   = 20
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key,
  output logic start,
  output logic key_release,
  output logic key_state
);

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_FILT   = 2'd1,
    DOWN         = 2'd2,
    RELEASE_FILT = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CNT_MAX - 1);

  logic             sync1;
  logic             sync2;
  logic             ks_d;
  logic             ks;
  logic             nedge;
  logic             pedge;

  state_t           state;
  state_t           state_nx;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nx;
  logic             start_nx;
  logic             key_release_nx;
  logic             key_state_nx;

  // Synchroniser and edge-detect delay; all reset to the released level so a
  // key held low through reset shows up as a fresh falling edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
      ks_d  <= 1'b1;
    end else begin
      sync1 <= key;
      sync2 <= sync1;
      ks_d  <= sync2;
    end
  end

  assign ks    = sync2;
  assign nedge = ks_d & ~ks;
  assign pedge = ~ks_d & ks;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      start       <= 1'b0;
      key_release <= 1'b0;
      key_state   <= 1'b0;
    end else begin
      state       <= state_nx;
      cnt         <= cnt_nx;
      start       <= start_nx;
      key_release <= key_release_nx;
      key_state   <= key_state_nx;
    end
  end

  always_comb begin
    state_nx       = state;
    cnt_nx         = cnt;
    start_nx       = 1'b0;
    key_release_nx = 1'b0;
    key_state_nx   = key_state;
    case (state)
      IDLE: begin
        if (nedge) begin
          state_nx = PRESS_FILT;
          cnt_nx   = '0;
        end
      end
      PRESS_FILT: begin
        if (ks) begin
          // Bounced back high: abandon and wait for the next falling edge.
          state_nx = IDLE;
          cnt_nx   = '0;
        end else if (cnt == CNT_LAST) begin
          state_nx     = DOWN;
          cnt_nx       = '0;
          start_nx     = 1'b1;
          key_state_nx = 1'b1;
        end else begin
          cnt_nx = cnt + CNT_W'(1);
        end
      end
      DOWN: begin
        if (pedge) begin
          state_nx = RELEASE_FILT;
          cnt_nx   = '0;
        end
      end
      RELEASE_FILT: begin
        if (!ks) begin
          state_nx = DOWN;
          cnt_nx   = '0;
        end else if (cnt == CNT_LAST) begin
          state_nx       = IDLE;
          cnt_nx         = '0;
          key_release_nx = 1'b1;
          key_state_nx   = 1'b0;
        end else begin
          cnt_nx = cnt + CNT_W'(1);
        end
      end
      default: begin
        state_nx = IDLE;
        cnt_nx   = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_key_filter_debounce.sv
// Testbench for key_filter_debounce with CNT_MAX = 16.
// Reference model: the synchronised key level is the raw key seen two clocks
// late. A level that differs from the debounced level and has been stable for
// CNT_MAX+1 synchronised cycles since its last transition is accepted; the
// matching pulse and level change appear one cycle later.
module tb_key_filter_debounce;

  localparam int unsigned CMAX = 16;
  localparam int unsigned CW   = 5;

  logic clk;
  logic rst_n;
  logic key;
  logic start;
  logic key_release;
  logic key_state;

  key_filter_debounce #(
    .CNT_MAX(CMAX),
    .CNT_W  (CW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .key        (key),
    .start      (start),
    .key_release(key_release),
    .key_state  (key_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  // model state
  logic        m_q1;
  logic        m_ks_last;
  int unsigned m_run;
  logic        p_start, p_rel, p_state;
  logic        m_start, m_rel, m_state;

  // observed event bookkeeping
  int cyc;
  int n_start, n_rel;
  int last_start_cyc, last_rel_cyc;

  task automatic chk(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%b expected=%b (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    vectors++;
    assert (obs == exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_q1      = 1'b1;
    m_ks_last = 1'b1;
    m_run     = CMAX + 2;
    p_start = 1'b0; p_rel = 1'b0; p_state = 1'b0;
    m_start = 1'b0; m_rel = 1'b0; m_state = 1'b0;
  endtask

  task automatic clear_events();
    n_start = 0; n_rel = 0; last_start_cyc = -1; last_rel_cyc = -1;
  endtask

  // One clock: drive key, step the model across the edge, compare outputs.
  task automatic tick(input logic kv);
    logic ks;
    key = kv;
    @(posedge clk);
    #1;
    cyc++;
    m_start = p_start;
    m_rel   = p_rel;
    m_state = p_state;
    ks   = m_q1;
    m_q1 = kv;
    if (ks == m_ks_last) begin
      if (m_run < CMAX + 2) m_run++;
    end else begin
      m_run = 1;
    end
    m_ks_last = ks;
    p_start = 1'b0;
    p_rel   = 1'b0;
    p_state = m_state;
    if (m_run == CMAX + 1) begin
      if (!ks && !m_state) begin
        p_start = 1'b1; p_state = 1'b1;
      end else if (ks && m_state) begin
        p_rel = 1'b1; p_state = 1'b0;
      end
    end
    if (start) begin n_start++; last_start_cyc = cyc; end
    if (key_release) begin n_rel++; last_rel_cyc = cyc; end
    chk("start", start, m_start);
    chk("key_release", key_release, m_rel);
    chk("key_state", key_state, m_state);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_start"}, start, 1'b0);
    chk({tag, "_release"}, key_release, 1'b0);
    chk({tag, "_state"}, key_state, 1'b0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int base;
    logic v;
    cyc   = 0;
    rst_n = 1'b0;
    key   = 1'b1;
    model_reset();
    clear_events();

    // 1. reset with key released
    repeat (5) begin
      @(posedge clk); #1;
      chk_reset_outputs("in_reset");
    end
    rst_n = 1'b1;
    model_reset();
    repeat (100) tick(1'b1);
    chk_int("idle_starts", n_start, 0);

    // 2. clean press, held 200+ cycles
    clear_events();
    tick(1'b0);
    base = cyc;
    repeat (220) tick(1'b0);
    chk_int("clean_start_count", n_start, 1);
    chk_int("clean_start_latency", last_start_cyc - base, 18);
    chk("clean_held_state", key_state, 1'b1);
    repeat (40) tick(1'b1);
    chk("clean_released_state", key_state, 1'b0);

    // 3. bouncy press: 5-cycle toggles for 60 cycles, then stable low
    clear_events();
    for (int i = 0; i < 12; i++) begin
      v = (i % 2 == 0) ? 1'b0 : 1'b1;
      repeat (5) tick(v);
    end
    tick(1'b0);
    base = cyc;
    repeat (60) tick(1'b0);
    chk_int("bouncy_start_count", n_start, 1);
    chk_int("bouncy_start_latency", last_start_cyc - base, 18);
    repeat (40) tick(1'b1);

    // 4. short glitch
    clear_events();
    repeat (10) tick(1'b0);
    repeat (100) tick(1'b1);
    chk_int("glitch_start_count", n_start, 0);
    chk("glitch_state", key_state, 1'b0);

    // 5. release with three random-length bounces
    repeat (40) tick(1'b0);
    chk("pre_release_state", key_state, 1'b1);
    clear_events();
    for (int b = 0; b < 3; b++) begin
      repeat ($urandom_range(1, 8)) tick(1'b1);
      repeat ($urandom_range(1, 8)) tick(1'b0);
    end
    tick(1'b1);
    base = cyc;
    repeat (60) tick(1'b1);
    chk_int("release_count", n_rel, 1);
    chk_int("release_latency", last_rel_cyc - base, 18);
    chk_int("release_no_start", n_start, 0);
    chk("release_state", key_state, 1'b0);

    // 6. reset in the middle of press qualification
    clear_events();
    repeat (10) tick(1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("async_reset");
    repeat (3) begin
      @(posedge clk); #1;
      chk_reset_outputs("mid_reset");
    end
    rst_n = 1'b1;
    model_reset();
    chk_int("abort_no_start", n_start, 0);
    tick(1'b0);
    base = cyc;
    repeat (40) tick(1'b0);
    chk_int("post_reset_start_count", n_start, 1);
    chk_int("post_reset_latency", last_start_cyc - base, 18);
    repeat (40) tick(1'b1);

    // 7. random runs around the qualification length
    v = 1'b1;
    for (int r = 0; r < 150; r++) begin
      v = ~v;
      repeat ($urandom_range(1, 2 * CMAX + 4)) tick(v);
    end
    repeat (40) tick(1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
